// File: rtl/clock_divider_n.sv
// -----------------------------------------------------------------------------
// clock_divider_n
//   N independent clock divider channels running off clk (clk100 domain).
//   Each channel has a runtime-programmable period (div) and high time (high),
//   a registered divided clock and a registered one-cycle tick that marks the
//   first cycle of every period (usable as a clock enable).
//
//   New div/high values land in a per-channel shadow register and are only
//   promoted to the active set at a period boundary (start, wrap or sync), so
//   clk_out never glitches mid-period.
//
// Ports
//   clk       input  1      clock
//   rst       input  1      asynchronous, active-high reset
//   en        input  N      per-channel run enable
//   sync      input  1      restart every running channel at count 0
//   cfg_wr    input  1      config write strobe
//   cfg_ch    input  3      channel index for cfg_wr (>= N is ignored)
//   cfg_div   input  WIDTH  new divisor (period in clk cycles)
//   cfg_high  input  WIDTH  new high time in clk cycles
//   clk_out   output N      divided clock per channel, registered
//   tick      output N      one-cycle pulse on the first cycle of each period
//   pending   output N      shadow config written but not yet applied
//
// Handshake: cfg_wr is a single-cycle strobe with no back-pressure; the write
// is always accepted on the edge where cfg_wr=1 and cfg_ch<N, and pending[ch]
// reports 1 from the following cycle until the shadow has been applied.
//
// Per-channel FSM state is observable hierarchically as ch_gen[i].state_q.
// -----------------------------------------------------------------------------
module clock_divider_n #(
  parameter int N            = 2,
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 10,
  parameter int DEFAULT_HIGH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     en,
  input  logic             sync,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic [N-1:0]     clk_out,
  output logic [N-1:0]     tick,
  output logic [N-1:0]     pending
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  for (genvar g = 0; g < N; g++) begin : ch_gen
    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] div_sh_q, div_sh_d;
    logic [WIDTH-1:0] high_sh_q, high_sh_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             apply;
    logic             wr_hit;

    assign wr_hit = cfg_wr && (cfg_ch == 3'(g));

    // State register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        div_q     <= RST_DIV;
        high_q    <= RST_HIGH;
        div_sh_q  <= RST_DIV;
        high_sh_q <= RST_HIGH;
        pend_q    <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        div_q     <= div_d;
        high_q    <= high_d;
        div_sh_q  <= div_sh_d;
        high_sh_q <= high_sh_d;
        pend_q    <= pend_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
      end
    end

    // Next-state, counter, config promotion and registered outputs.
    // The shadow always equals the active set when nothing is pending, so the
    // shadow divisor is the divisor that will be in force after any boundary.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      high_d    = high_q;
      div_sh_d  = div_sh_q;
      high_sh_d = high_sh_q;
      pend_d    = pend_q;
      clk_d     = 1'b0;
      tick_d    = 1'b0;
      apply     = 1'b0;

      case (state_q)
        IDLE: begin
          // A zero divisor keeps the channel parked regardless of en.
          if (en[g] && (div_sh_q != '0)) begin
            state_d = RUN;
            cnt_d   = '0;
            apply   = 1'b1;
          end
        end
        RUN: begin
          if (!en[g]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (sync || (cnt_q == div_q - ONE)) begin
            // Boundary: wrap with the old divisor, then promote the shadow.
            cnt_d = '0;
            apply = 1'b1;
            if (div_sh_q == '0) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      if (apply) begin
        div_d  = div_sh_q;
        high_d = high_sh_q;
        pend_d = 1'b0;
      end

      // A write on a boundary edge lands in the shadow after the old shadow
      // has been promoted, so it waits for the following boundary.
      if (wr_hit) begin
        div_sh_d  = cfg_div;
        high_sh_d = cfg_high;
        pend_d    = 1'b1;
      end

      // Outputs are registered from the next count so they line up with cnt.
      if (state_d == RUN) begin
        clk_d  = (cnt_d < high_d);
        tick_d = (cnt_d == '0);
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end : ch_gen

endmodule

// File: tb/tb_clock_divider_n.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_n
//   Directed bench for clock_divider_n (N=2, WIDTH=8, defaults 10/5).
//   A small per-channel phase model (run flag, phase, div, high) is steered by
//   hand at each directed step; every clock edge compares clk_out, tick and
//   pending against it.
// -----------------------------------------------------------------------------
module tb_clock_divider_n;

  localparam int N     = 2;
  localparam int WIDTH = 8;

  // Clock / reset
  logic             clk;
  logic             rst;
  logic [N-1:0]     en;
  logic             sync;
  logic             cfg_wr;
  logic [2:0]       cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;
  logic [N-1:0]     clk_out;
  logic [N-1:0]     tick;
  logic [N-1:0]     pending;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clock_divider_n #(
    .N(N), .WIDTH(WIDTH), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  // Scoreboard state
  int checks   = 0;
  int failures = 0;

  // Expected-behaviour model, updated by hand at directed steps
  bit run_m [N];
  int ph    [N];
  int dv    [N];
  int hi    [N];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge, then compare all outputs with the model.
  task automatic step_chk(input logic [N-1:0] exp_pend);
    logic [N-1:0] e_clk;
    logic [N-1:0] e_tick;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (run_m[c]) begin
        e_clk[c]  = (ph[c] < hi[c]);
        e_tick[c] = (ph[c] == 0);
        ph[c]     = (ph[c] == dv[c] - 1) ? 0 : ph[c] + 1;
      end else begin
        e_clk[c]  = 1'b0;
        e_tick[c] = 1'b0;
      end
    end
    chk("clk_out", clk_out, e_clk);
    chk("tick", tick, e_tick);
    chk("pending", pending, exp_pend);
  endtask

  task automatic cfg(input logic [2:0] ch, input int d, input int h);
    cfg_wr   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = WIDTH'(d);
    cfg_high = WIDTH'(h);
  endtask

  task automatic model_defaults();
    for (int c = 0; c < N; c++) begin
      run_m[c] = 1'b0;
      ph[c]    = 0;
      dv[c]    = 10;
      hi[c]    = 5;
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = '0;
    sync     = 1'b0;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_high = '0;
    model_defaults();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", clk_out, 2'b00);
    chk("rst_tick", tick, 2'b00);
    chk("rst_pending", pending, 2'b00);

    // Defaults: ch0 divides by 10 with 5 high cycles, first tick on start edge
    rst = 1'b0;
    en  = 2'b01;
    run_m[0] = 1'b1;
    ph[0]    = 0;
    repeat (22) step_chk(2'b00);

    // Mid-period reprogram of ch0 to div=4 high=1
    cfg(3'd0, 4, 1);
    step_chk(2'b01);
    cfg_wr = 1'b0;
    repeat (7) step_chk(2'b01);
    dv[0] = 4;
    hi[0] = 1;
    repeat (12) step_chk(2'b00);

    // div=1 high=1 on ch1: written while idle, applied on start
    cfg(3'd1, 1, 1);
    step_chk(2'b10);
    cfg_wr = 1'b0;
    en = 2'b11;
    run_m[1] = 1'b1;
    ph[1]    = 0;
    dv[1]    = 1;
    hi[1]    = 1;
    repeat (5) step_chk(2'b00);

    // div=0 written on a boundary edge: takes effect one boundary later
    cfg(3'd1, 0, 0);
    step_chk(2'b10);
    cfg_wr = 1'b0;
    run_m[1] = 1'b0;
    repeat (3) step_chk(2'b00);

    // div=6 high=0 while parked with en=1: starts on the edge after the write
    cfg(3'd1, 6, 0);
    step_chk(2'b10);
    cfg_wr = 1'b0;
    run_m[1] = 1'b1;
    ph[1]    = 0;
    dv[1]    = 6;
    hi[1]    = 0;
    repeat (12) step_chk(2'b00);

    // high=9 > div=6, written on a boundary edge
    cfg(3'd1, 6, 9);
    step_chk(2'b10);
    cfg_wr = 1'b0;
    repeat (5) step_chk(2'b10);
    hi[1] = 9;
    repeat (12) step_chk(2'b00);

    // Sync alignment: ch0 10/5 and ch1 5/2, started 3 cycles apart
    en = 2'b00;
    run_m[0] = 1'b0;
    run_m[1] = 1'b0;
    step_chk(2'b00);
    cfg(3'd0, 10, 5);
    step_chk(2'b01);
    cfg(3'd1, 5, 2);
    step_chk(2'b11);
    cfg_wr = 1'b0;
    en = 2'b01;
    run_m[0] = 1'b1;
    ph[0]    = 0;
    dv[0]    = 10;
    hi[0]    = 5;
    repeat (3) step_chk(2'b10);
    en = 2'b11;
    run_m[1] = 1'b1;
    ph[1]    = 0;
    dv[1]    = 5;
    hi[1]    = 2;
    repeat (4) step_chk(2'b00);
    sync  = 1'b1;
    ph[0] = 0;
    ph[1] = 0;
    step_chk(2'b00);
    sync = 1'b0;
    repeat (12) step_chk(2'b00);

    // Drop en[0] mid-period, then restart
    en = 2'b10;
    run_m[0] = 1'b0;
    repeat (2) step_chk(2'b00);
    en = 2'b11;
    run_m[0] = 1'b1;
    ph[0]    = 0;
    repeat (4) step_chk(2'b00);

    // Out-of-range channel indices are ignored
    cfg(3'd2, 3, 1);
    step_chk(2'b00);
    cfg(3'd7, 3, 1);
    step_chk(2'b00);
    cfg_wr = 1'b0;
    repeat (12) step_chk(2'b00);

    // Async reset between edges with a write pending
    cfg(3'd0, 3, 2);
    step_chk(2'b01);
    cfg_wr = 1'b0;
    #3;
    rst = 1'b1;
    en  = 2'b00;
    #1;
    chk("async_rst_clk_out", clk_out, 2'b00);
    chk("async_rst_tick", tick, 2'b00);
    chk("async_rst_pending", pending, 2'b00);
    @(posedge clk);
    #1;
    chk("hold_rst_clk_out", clk_out, 2'b00);
    rst = 1'b0;

    // Defaults restored, including the shadow
    model_defaults();
    en = 2'b01;
    run_m[0] = 1'b1;
    ph[0]    = 0;
    repeat (12) step_chk(2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
